// File: rtl/div_pkg.sv
// Shared types and constants for the shared-divider sequencer.
package div_pkg;

  localparam int unsigned DIV_W = 16;
  localparam logic [DIV_W-1:0] DBZ_QUOTIENT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  // Magnitude of a two's complement operand; 16'h8000 maps to itself,
  // which the unsigned core reads as 32768.
  function automatic logic [DIV_W-1:0] abs16(input logic [DIV_W-1:0] v);
    return v[DIV_W-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/attemptSubtractDivision.sv
// Combinational 16-bit restoring divider core (long ripple path).
// Quotient is undefined-by-contract for divisor 0; callers bypass it.
module attemptSubtractDivision (
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  output logic [15:0] quotient
);

  logic [16:0] rem;

  // Shift-and-subtract, one quotient bit per stage, MSB first.
  always_comb begin
    rem      = '0;
    quotient = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      rem = {rem[15:0], dividend[15-k]};
      if (rem >= {1'b0, divisor}) begin
        rem           = rem - {1'b0, divisor};
        quotient[15-k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr and wraps;
// the first asserted request wins. Grant is one-hot or zero.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  // Rotating priority scan from ptr.
  always_comb begin
    logic        found;
    int unsigned idx;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = (32'(ptr) + off) % NUM_REQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_share_ctrl.sv
// Sequencer and round-robin arbiter sharing one combinational divider
// core between NUM_REQ requesters. Operands are registered and held for
// DIV_LATENCY cycles so the core path can be timed as a multicycle path.
// Optional macro SIGNED_DIV_EN: two's complement operands, quotient
// truncated toward zero.
module div_share_ctrl
  import div_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned ID_W        = 1,
  parameter int unsigned DIV_LATENCY = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [16*NUM_REQ-1:0]    req_dividend,
  input  logic [16*NUM_REQ-1:0]    req_divisor,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [ID_W-1:0]          resp_id,
  output logic [15:0]              resp_quotient,
  output logic                     resp_dbz,
  output logic                     busy
);

  localparam int unsigned CNT_W = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;

  if (DIV_LATENCY < 1) begin : g_bad_latency
    $error("div_share_ctrl: DIV_LATENCY must be at least 1");
  end
  if (NUM_REQ < 2) begin : g_bad_num_req
    $error("div_share_ctrl: NUM_REQ must be at least 2");
  end
  if ((1 << ID_W) < NUM_REQ) begin : g_bad_id_w
    $error("div_share_ctrl: ID_W too narrow for NUM_REQ");
  end

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [DIV_W-1:0]  dividend_q, dividend_d;
  logic [DIV_W-1:0]  divisor_q, divisor_d;
  logic [DIV_W-1:0]  result_q, result_d;
  logic              dbz_q, dbz_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    gidx;
  logic [DIV_W-1:0]   sel_dividend, sel_divisor;
  logic [DIV_W-1:0]   core_a, core_b, core_q, quot_fix;
  logic               accept;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (ID_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (grant)
  );

  // Encode the one-hot grant and select the winning operand slices.
  always_comb begin
    gidx         = '0;
    sel_dividend = '0;
    sel_divisor  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        gidx         = ID_W'(i);
        sel_dividend = req_dividend[i*DIV_W +: DIV_W];
        sel_divisor  = req_divisor[i*DIV_W +: DIV_W];
      end
    end
  end

  assign req_ready = (state_q == IDLE) ? grant : '0;
  assign accept    = |(req_valid & req_ready);

`ifdef SIGNED_DIV_EN
  assign core_a   = abs16(dividend_q);
  assign core_b   = abs16(divisor_q);
  assign quot_fix = (dividend_q[DIV_W-1] ^ divisor_q[DIV_W-1]) ? (~core_q + 1'b1) : core_q;
`else
  assign core_a   = dividend_q;
  assign core_b   = divisor_q;
  assign quot_fix = core_q;
`endif

  attemptSubtractDivision u_core (
    .dividend (core_a),
    .divisor  (core_b),
    .quotient (core_q)
  );

  // Next-state and datapath register updates for IDLE/WAIT/DONE.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    id_d       = id_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    result_d   = result_q;
    dbz_d      = dbz_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          dividend_d = sel_dividend;
          divisor_d  = sel_divisor;
          id_d       = gidx;
          rr_ptr_d   = (32'(gidx) == NUM_REQ - 1) ? '0 : gidx + 1'b1;
          // Zero divisor takes a single WAIT cycle so the response still
          // lands one edge after accept; the core output is ignored.
          cnt_d      = (sel_divisor == '0) ? '0 : CNT_W'(DIV_LATENCY - 1);
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          if (divisor_q == '0) begin
            result_d = DBZ_QUOTIENT;
            dbz_d    = 1'b1;
          end else begin
            result_d = quot_fix;
            dbz_d    = 1'b0;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      id_q       <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      result_q   <= '0;
      dbz_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      id_q       <= id_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      result_q   <= result_d;
      dbz_q      <= dbz_d;
      cnt_q      <= cnt_d;
    end
  end

  assign resp_valid    = (state_q == DONE);
  assign resp_id       = id_q;
  assign resp_quotient = result_q;
  assign resp_dbz      = dbz_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_div_share_ctrl.sv
// Directed bench for div_share_ctrl (NUM_REQ=2, ID_W=1, DIV_LATENCY=4).
module tb_div_share_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_dividend;
  logic [31:0] req_divisor;
  logic        resp_valid;
  logic        resp_ready;
  logic [0:0]  resp_id;
  logic [15:0] resp_quotient;
  logic        resp_dbz;
  logic        busy;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  div_share_ctrl #(
    .NUM_REQ     (2),
    .ID_W        (1),
    .DIV_LATENCY (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_dividend  (req_dividend),
    .req_divisor   (req_divisor),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_id       (resp_id),
    .resp_quotient (resp_quotient),
    .resp_dbz      (resp_dbz),
    .busy          (busy)
  );

  typedef struct {
    int          id;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vec[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic run_op(input vec_t v, input string nm);
    int n;
    int lat;
    @(negedge clk);
    req_valid = '0;
    req_valid[v.id] = 1'b1;
    req_dividend[v.id*16 +: 16] = v.a;
    req_divisor[v.id*16 +: 16]  = v.b;
    #1;
    n = 0;
    while (!req_ready[v.id] && n < 50) begin
      @(negedge clk); #1; n++;
    end
    chk({nm, " grant"}, 32'(req_ready[v.id]), 32'd1);
    @(posedge clk);
    #1;
    req_valid = '0;
    lat = 0;
    while (!resp_valid && lat < 50) begin
      @(posedge clk); lat++; #1;
    end
    chk({nm, " latency"}, 32'(lat), 32'(v.lat));
    chk({nm, " quotient"}, 32'(resp_quotient), 32'(v.q));
    chk({nm, " dbz"}, 32'(resp_dbz), 32'(v.dbz));
    chk({nm, " id"}, 32'(resp_id), 32'(v.id));
    @(posedge clk);
    #1;
    chk({nm, " busy after handshake"}, 32'(busy), 32'd0);
  endtask

  // Both requesters raise valid together; responses collected in order.
  task automatic run_pair(input int first, input string nm);
    int          got;
    int          n;
    int          ids[2];
    logic [15:0] qs[2];
    logic        acc[2];
    logic        onehot_ok;
    logic [15:0] expq[2];
    expq[0] = 16'd10;
    expq[1] = 16'd3;
    @(negedge clk);
    req_dividend = {16'd9, 16'd50};
    req_divisor  = {16'd3, 16'd5};
    req_valid    = 2'b11;
    got = 0; n = 0; onehot_ok = 1'b1;
    acc[0] = 1'b0; acc[1] = 1'b0;
    ids[0] = -1; ids[1] = -1; qs[0] = '0; qs[1] = '0;
    while (got < 2 && n < 60) begin
      #1;
      if ($countones(req_ready) > 1) onehot_ok = 1'b0;
      for (int i = 0; i < 2; i++)
        if (req_valid[i] && req_ready[i]) acc[i] = 1'b1;
      if (resp_valid && resp_ready) begin
        ids[got] = int'(resp_id);
        qs[got]  = resp_quotient;
        got++;
      end
      @(negedge clk);
      n++;
      for (int i = 0; i < 2; i++)
        if (acc[i]) begin
          req_valid[i] = 1'b0;
          acc[i] = 1'b0;
        end
    end
    req_valid = '0;
    chk({nm, " responses"}, 32'(got), 32'd2);
    chk({nm, " ready one-hot"}, 32'(onehot_ok), 32'd1);
    chk({nm, " first id"}, 32'(ids[0]), 32'(first));
    chk({nm, " first q"}, 32'(qs[0]), 32'(expq[first]));
    chk({nm, " second id"}, 32'(ids[1]), 32'(1 - first));
    chk({nm, " second q"}, 32'(qs[1]), 32'(expq[1 - first]));
  endtask

  task automatic hold_test();
    int          n;
    logic        stable_ok;
    logic [15:0] q0;
    @(negedge clk);
    resp_ready = 1'b0;
    req_dividend[15:0] = 16'd200;
    req_divisor[15:0]  = 16'd10;
    req_valid = 2'b01;
    @(posedge clk);
    #1;
    req_valid = '0;
    n = 0;
    while (!resp_valid && n < 50) begin
      @(posedge clk); n++; #1;
    end
    chk("hold resp_valid", 32'(resp_valid), 32'd1);
    q0 = resp_quotient;
    chk("hold quotient", 32'(q0), 32'd20);
    req_dividend[31:16] = 16'd77;
    req_divisor[31:16]  = 16'd7;
    req_valid = 2'b10;
    stable_ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      if (!resp_valid || resp_quotient != q0 || resp_id != 1'b0 ||
          resp_dbz || req_ready != 2'b00 || !busy)
        stable_ok = 1'b0;
    end
    chk("hold stable 10 cycles", 32'(stable_ok), 32'd1);
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release to IDLE", 32'(busy), 32'd0);
    chk("release pending ready", 32'(req_ready), 32'h2);
    @(posedge clk);
    #1;
    chk("pending accepted", 32'(busy), 32'd1);
    req_valid = '0;
    n = 0;
    while (!resp_valid && n < 50) begin
      @(posedge clk); n++; #1;
    end
    chk("pending quotient", 32'(resp_quotient), 32'd11);
    chk("pending id", 32'(resp_id), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_test();
    logic seen;
    @(negedge clk);
    req_dividend[15:0] = 16'd300;
    req_divisor[15:0]  = 16'd3;
    req_valid = 2'b01;
    @(posedge clk);
    #1;
    req_valid = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("mid-WAIT busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset resp_valid", 32'(resp_valid), 32'd0);
    chk("async reset busy", 32'(busy), 32'd0);
    chk("async reset quotient", 32'(resp_quotient), 32'd0);
    chk("async reset dbz", 32'(resp_dbz), 32'd0);
    chk("async reset id", 32'(resp_id), 32'd0);
    chk("async reset req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    chk("no response after reset", 32'(seen), 32'd0);
  endtask

  initial begin
    vec[0]  = '{0, 16'd100,   16'd7,    16'd14,   1'b0, 4};
    vec[1]  = '{1, 16'd1234,  16'd0,    16'hFFFF, 1'b1, 1};
    vec[2]  = '{0, 16'd5,     16'd9,    16'd0,    1'b0, 4};
    vec[3]  = '{1, 16'd12345, 16'd1,    16'd12345,1'b0, 4};
    vec[4]  = '{0, 16'hFFFF,  16'd1,    16'hFFFF, 1'b0, 4};
    vec[5]  = '{0, 16'd1000,  16'd1000, 16'd1,    1'b0, 4};
    vec[6]  = '{1, 16'd0,     16'd5,    16'd0,    1'b0, 4};
    vec[7]  = '{0, 16'd0,     16'd0,    16'hFFFF, 1'b1, 1};
`ifdef SIGNED_DIV_EN
    vec[8]  = '{0, 16'hFF9C,  16'd7,    16'hFFF2, 1'b0, 4};
    vec[9]  = '{0, 16'h8000,  16'hFFFF, 16'h8000, 1'b0, 4};
    vec[10] = '{0, 16'hFFFF,  16'd255,  16'd0,    1'b0, 4};
    vec[11] = '{1, 16'd100,   16'hFFF9, 16'hFFF2, 1'b0, 4};
`else
    vec[8]  = '{0, 16'hFF9C,  16'd7,    16'h2484, 1'b0, 4};
    vec[9]  = '{0, 16'h8000,  16'hFFFF, 16'd0,    1'b0, 4};
    vec[10] = '{0, 16'hFFFF,  16'd255,  16'd257,  1'b0, 4};
    vec[11] = '{1, 16'd100,   16'hFFF9, 16'd0,    1'b0, 4};
`endif

    rst_n        = 1'b0;
    req_valid    = '0;
    req_dividend = '0;
    req_divisor  = '0;
    resp_ready   = 1'b1;
    #12;
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset quotient", 32'(resp_quotient), 32'd0);
    chk("reset req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_op(vec[i], $sformatf("vec%0d", i));

    // Last vector was requester 1, so the pointer is back at 0.
    run_pair(0, "pair ptr0");
    run_op(vec[0], "single req0");
    run_pair(1, "pair ptr1");
    hold_test();
    // Requester 0 is accepted before the reset, which would move the
    // pointer to 1; the pair afterwards shows it was cleared.
    reset_test();
    run_pair(0, "pair after reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
